regfile_multiport: RTL

//  Parametrised integer register file for the pipelined RV32 core.
//  - N registered read ports, M write ports, optional same-cycle write->read bypass.
//  - Per-register busy scoreboard: decode claims a destination, writeback releases it.
//  - Sits between decode (reads, claims) and writeback (writes, releases).

---
 rtl/regfile_multiport_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/regfile_multiport.sv | 110 +++++++++++
 3 files changed

// File: rtl/regfile_multiport_pkg.sv
// Core package: register-file widths, architectural register address and write-port payload.
package regfile_multiport_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned RF_NUM_REGS   = 32;
    localparam int unsigned RF_NUM_REGS_E = 16;

    typedef logic [REG_ADDR_W-1:0] rv_reg_t;

    typedef struct packed {
        logic            enable;
        rv_reg_t         which_register;
        logic [XLEN-1:0] value;
    } reg_write_control_t;

    // x0 and addresses beyond the implemented file never hold state.
    function automatic logic rf_addr_valid(input rv_reg_t addr, input int unsigned num_regs);
        return (addr != '0) && (32'(addr) < num_regs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: decode claims a destination, writeback releases it, flush clears all.
module regfile_scoreboard
    import regfile_multiport_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_WRITE = 1
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                claim_en,
    input  rv_reg_t                             claim_reg,
    input  logic                                flush,
    input  reg_write_control_t [NUM_WRITE-1:0]  wr_ctrl,
    output logic [NUM_REGS-1:0]                 busy_vec
);

    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] busy_d;
    logic                claim_ok;

    assign claim_ok = claim_en && rf_addr_valid(claim_reg, NUM_REGS);

    // Any enabled write port targeting r releases it.
    always_comb begin
        wr_hit = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            for (int unsigned i = 0; i < NUM_WRITE; i++) begin
                if (wr_ctrl[i].enable && (wr_ctrl[i].which_register == REG_ADDR_W'(r))) begin
                    wr_hit[r] = 1'b1;
                end
            end
        end
    end

    // Flush beats claim, claim beats release.
    always_comb begin
        busy_d = busy_vec;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (claim_ok && (claim_reg == REG_ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport integer register file with registered reads, optional write bypass and busy scoreboard.
module regfile_multiport
    import regfile_multiport_pkg::*;
#(
    parameter int unsigned NUM_REGS       = RF_NUM_REGS,
    parameter int unsigned NUM_READ       = 2,
    parameter int unsigned NUM_WRITE      = 1,
    parameter int unsigned WRITE_BYPASS   = 1,
    parameter int unsigned HAS_SCOREBOARD = 1
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  rv_reg_t [NUM_READ-1:0]              rd_addr,
    input  logic [NUM_READ-1:0]                 rd_en,
    output logic [NUM_READ-1:0][XLEN-1:0]       rd_data,
    output logic [NUM_READ-1:0]                 rd_busy,
    input  reg_write_control_t [NUM_WRITE-1:0]  wr_ctrl,
    input  logic                                claim_en,
    input  rv_reg_t                             claim_reg,
    input  logic                                flush,
    output logic [NUM_REGS-1:0]                 busy_vec
);

    logic [XLEN-1:0]                regs     [NUM_REGS];
    logic [XLEN-1:0]                reg_next [NUM_REGS];
    logic [NUM_READ-1:0][XLEN-1:0]  rd_data_d;
    logic [NUM_READ-1:0]            rd_busy_d;

    // Write merge: later ports override earlier ones, so the highest index wins.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_merge
        if (r == 0) begin : g_zero
            assign reg_next[r] = '0;
        end else begin : g_reg
            logic [XLEN-1:0] merged;
            always_comb begin
                merged = regs[r];
                for (int unsigned i = 0; i < NUM_WRITE; i++) begin
                    if (wr_ctrl[i].enable && (wr_ctrl[i].which_register == REG_ADDR_W'(r))) begin
                        merged = wr_ctrl[i].value;
                    end
                end
            end
            assign reg_next[r] = merged;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= reg_next[r];
            end
        end
    end

    // Read mux per port; bypass forwards the merged next value, busy is always pre-edge.
    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [XLEN-1:0] data_c;
        logic            busy_c;
        always_comb begin
            data_c = '0;
            busy_c = 1'b0;
            if (rf_addr_valid(rd_addr[p], NUM_REGS)) begin
                for (int unsigned r = 1; r < NUM_REGS; r++) begin
                    if (rd_addr[p] == REG_ADDR_W'(r)) begin
                        data_c = (WRITE_BYPASS != 0) ? reg_next[r] : regs[r];
                        busy_c = busy_vec[r];
                    end
                end
            end
        end
        assign rd_data_d[p] = data_c;
        assign rd_busy_d[p] = busy_c;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_READ; p++) begin
                if (rd_en[p]) begin
                    rd_data[p] <= rd_data_d[p];
                    rd_busy[p] <= rd_busy_d[p];
                end
            end
        end
    end

    if (HAS_SCOREBOARD != 0) begin : g_sb
        regfile_scoreboard #(
            .NUM_REGS  (NUM_REGS),
            .NUM_WRITE (NUM_WRITE)
        ) u_scoreboard (
            .clock     (clock),
            .reset_n   (reset_n),
            .claim_en  (claim_en),
            .claim_reg (claim_reg),
            .flush     (flush),
            .wr_ctrl   (wr_ctrl),
            .busy_vec  (busy_vec)
        );
    end else begin : g_no_sb
        assign busy_vec = '0;
    end

endmodule
